// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the TCDM bank arbiter.
// Perf counters are enabled by defining TCDM_BANK_ARB_PERF_EN.
`ifndef TCDM_ARB_META_T
`define TCDM_ARB_META_T(name, idx_w, meta_t) \
  typedef struct packed { \
    logic [(idx_w)-1:0] idx; \
    meta_t meta; \
  } name;
`endif

package tcdm_arb_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_t;

  function automatic int unsigned idx_width(
    input int unsigned n
  );
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/tcdm_arb_credit_cnt.sv
// Outstanding-response credit counter for one arbiter port.
// Simultaneous increment and decrement leave the count unchanged.
module tcdm_arb_credit_cnt
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned MaxCount = 4,
  parameter int unsigned CntWidth = idx_width(MaxCount + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [CntWidth-1:0] cnt_q;

  assign full_o  = (cnt_q == CntWidth'(MaxCount));
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  a_no_overflow : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && full_o));

  a_no_underflow : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && empty_o));

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank among NumPorts requesters.
// Optional perf counters: define TCDM_BANK_ARB_PERF_EN.
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         metadata_t     = logic,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned MetaWidth      = $bits(metadata_t),
  parameter int unsigned IdxWidth       = idx_width(NumPorts)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumPorts-1:0]           req_valid_i,
  output logic [NumPorts-1:0]           req_ready_o,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_i,
  input  logic [NumPorts*4-1:0]         req_amo_i,
  input  logic [NumPorts-1:0]           req_write_i,
  input  logic [NumPorts*DataWidth-1:0] req_wdata_i,
  input  logic [NumPorts*BeWidth-1:0]   req_be_i,
  input  logic [NumPorts*MetaWidth-1:0] req_meta_i,
  output logic [NumPorts-1:0]           rsp_valid_o,
  input  logic [NumPorts-1:0]           rsp_ready_i,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output metadata_t                     rsp_meta_o,
  output logic                          bank_valid_o,
  input  logic                          bank_ready_i,
  output logic [AddrWidth-1:0]          bank_addr_o,
  output amo_op_t                       bank_amo_o,
  output logic                          bank_write_o,
  output logic [DataWidth-1:0]          bank_wdata_o,
  output logic [BeWidth-1:0]            bank_be_o,
  output logic [IdxWidth+MetaWidth-1:0] bank_meta_o,
  input  logic                          bank_rsp_valid_i,
  output logic                          bank_rsp_ready_o,
  input  logic [DataWidth-1:0]          bank_rsp_rdata_i,
`ifdef TCDM_BANK_ARB_PERF_EN
  output logic [NumPorts*32-1:0]        perf_grant_o,
  output logic [31:0]                   perf_conflict_o,
`endif
  input  logic [IdxWidth+MetaWidth-1:0] bank_rsp_meta_i
);

  `TCDM_ARB_META_T(arb_meta_t, IdxWidth, metadata_t)

  typedef logic [IdxWidth-1:0] idx_t;

  logic [NumPorts-1:0] needs_rsp, eligible;
  logic [NumPorts-1:0] full, empty;
  logic [NumPorts-1:0] cnt_inc, cnt_dec;
  idx_t                rr_q, lock_idx_q, winner, rsp_idx;
  logic                lock_q, any_elig, hs;
  arb_meta_t           req_meta, rsp_meta;

  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      needs_rsp[i] = !req_write_i[i] ||
                     (req_amo_i[i*4 +: 4] != 4'h0);
      eligible[i]  = req_valid_i[i] &&
                     !(needs_rsp[i] && full[i]);
    end
  end

  // A stalled grant is pinned so the bank sees stable fields.
  always_comb begin
    int unsigned j;
    j        = 0;
    winner   = rr_q;
    any_elig = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      j = 32'(rr_q) + k;
      if (j >= NumPorts) j = j - NumPorts;
      if (!any_elig && eligible[idx_t'(j)]) begin
        any_elig = 1'b1;
        winner   = idx_t'(j);
      end
    end
    if (lock_q) begin
      winner   = lock_idx_q;
      any_elig = eligible[lock_idx_q];
    end
  end

  assign bank_valid_o = any_elig && !rst_i;
  assign hs           = bank_valid_o && bank_ready_i;

  always_comb begin
    req_ready_o         = '0;
    req_ready_o[winner] = hs;
  end

  assign bank_addr_o  = req_addr_i[winner*AddrWidth +: AddrWidth];
  assign bank_amo_o   = amo_op_t'(req_amo_i[winner*4 +: 4]);
  assign bank_write_o = req_write_i[winner];
  assign bank_wdata_o = req_wdata_i[winner*DataWidth +: DataWidth];
  assign bank_be_o    = req_be_i[winner*BeWidth +: BeWidth];

  always_comb begin
    req_meta.idx  = winner;
    req_meta.meta = req_meta_i[winner*MetaWidth +: MetaWidth];
  end

  assign bank_meta_o = req_meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      lock_q <= 1'b0;
      rr_q   <= (32'(winner) == NumPorts - 1) ?
                '0 : winner + 1'b1;
    end else if (bank_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end
  end

  assign rsp_meta = bank_rsp_meta_i;
  assign rsp_idx  = rsp_meta.idx;

  always_comb begin
    rsp_valid_o      = '0;
    bank_rsp_ready_o = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (rsp_idx == idx_t'(i)) begin
        rsp_valid_o[i]   = bank_rsp_valid_i && !rst_i;
        bank_rsp_ready_o = rsp_ready_i[i];
      end
    end
  end

  assign rsp_rdata_o = bank_rsp_rdata_i;
  assign rsp_meta_o  = rsp_meta.meta;

  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cnt_inc[i] = hs && (winner == idx_t'(i)) && needs_rsp[i];
      cnt_dec[i] = rsp_valid_o[i] && rsp_ready_i[i];
    end
  end

  for (genvar g = 0; g < NumPorts; g++) begin : gen_cnt
    tcdm_arb_credit_cnt #(
      .MaxCount (MaxOutstanding)
    ) i_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (cnt_inc[g]),
      .dec_i   (cnt_dec[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  a_rsp_has_credit : assert property (
    @(posedge clk_i) disable iff (rst_i)
    bank_rsp_valid_i |-> !empty[rsp_idx]);

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [NumPorts-1:0][31:0] perf_grant_q;
  logic [31:0]               perf_conflict_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_grant_q    <= '0;
      perf_conflict_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (hs && winner == idx_t'(i) &&
            perf_grant_q[i] != '1) begin
          perf_grant_q[i] <= perf_grant_q[i] + 1'b1;
        end
      end
      if ($countones(eligible) > 1 &&
          perf_conflict_q != '1) begin
        perf_conflict_q <= perf_conflict_q + 1'b1;
      end
    end
  end

  assign perf_grant_o    = perf_grant_q;
  assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Scoreboard bench for tcdm_bank_arbiter.
// Define TCDM_BANK_ARB_PERF_EN to also exercise the perf counters.
module tb_tcdm_bank_arbiter;
  import tcdm_arb_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MW = 1;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;

  logic [NP-1:0]    req_valid, req_ready, req_write;
  logic [NP-1:0]    rsp_valid, rsp_ready;
  logic [NP*AW-1:0] req_addr;
  logic [NP*4-1:0]  req_amo;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*BW-1:0] req_be;
  logic [NP*MW-1:0] req_meta;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_meta;

  logic             bank_valid, bank_ready, bank_write;
  logic [AW-1:0]    bank_addr;
  amo_op_t          bank_amo;
  logic [DW-1:0]    bank_wdata;
  logic [BW-1:0]    bank_be;
  logic [IW+MW-1:0] bank_meta;
  logic             bank_rsp_valid, bank_rsp_ready;
  logic [DW-1:0]    bank_rsp_rdata;
  logic [IW+MW-1:0] bank_rsp_meta;
`ifdef TCDM_BANK_ARB_PERF_EN
  logic [NP*32-1:0] perf_grant;
  logic [31:0]      perf_conflict;
`endif

  always #5 clk = ~clk;

  tcdm_bank_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .req_amo_i        (req_amo),
    .req_write_i      (req_write),
    .req_wdata_i      (req_wdata),
    .req_be_i         (req_be),
    .req_meta_i       (req_meta),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_rdata_o      (rsp_rdata),
    .rsp_meta_o       (rsp_meta),
    .bank_valid_o     (bank_valid),
    .bank_ready_i     (bank_ready),
    .bank_addr_o      (bank_addr),
    .bank_amo_o       (bank_amo),
    .bank_write_o     (bank_write),
    .bank_wdata_o     (bank_wdata),
    .bank_be_o        (bank_be),
    .bank_meta_o      (bank_meta),
    .bank_rsp_valid_i (bank_rsp_valid),
    .bank_rsp_ready_o (bank_rsp_ready),
    .bank_rsp_rdata_i (bank_rsp_rdata),
`ifdef TCDM_BANK_ARB_PERF_EN
    .perf_grant_o     (perf_grant),
    .perf_conflict_o  (perf_conflict),
`endif
    .bank_rsp_meta_i  (bank_rsp_meta)
  );

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
  } gnt_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        meta;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [31:0] addr_of(input int p);
    return 32'h1000_0000 + 32'(p) * 32'h40;
  endfunction

  function automatic logic [31:0] wdata_of(input int p);
    return 32'hCAFE_0000 | 32'(p);
  endfunction

  function automatic logic [3:0] be_of(input int p);
    return 4'(p + 1);
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  task automatic set_req(input int p, input logic v,
                         input logic w,
                         input logic [3:0] a);
    req_valid[p]       = v;
    req_write[p]       = w;
    req_amo[p*4 +: 4]  = a;
  endtask

  task automatic exp_gnt(input int p);
    gnt_t g;
    g.port  = p;
    g.addr  = addr_of(p);
    g.write = req_write[p];
    g.amo   = req_amo[p*4 +: 4];
    gnt_q.push_back(g);
  endtask

  task automatic exp_rsp(input int p, input logic [31:0] d,
                         input logic m);
    rsp_t r;
    r.port = p;
    r.data = d;
    r.meta = m;
    rsp_q.push_back(r);
  endtask

  // Inputs change just after negedge; outputs are sampled before posedge.
  task automatic tick();
    gnt_t g;
    rsp_t r;
    #1;
    if (bank_valid && bank_ready) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexp", 64'(bank_meta), 64'hFFFF);
      end else begin
        g = gnt_q.pop_front();
        check("gnt_port", 64'(bank_meta[IW+MW-1:MW]),
              64'(g.port));
        check("gnt_addr", 64'(bank_addr), 64'(g.addr));
        check("gnt_write", 64'(bank_write), 64'(g.write));
        check("gnt_amo", 64'(bank_amo), 64'(g.amo));
        check("gnt_wdata", 64'(bank_wdata),
              64'(wdata_of(g.port)));
        check("gnt_be", 64'(bank_be), 64'(be_of(g.port)));
        check("gnt_meta", 64'(bank_meta[0]),
              64'(g.port & 1));
      end
    end
    if (bank_rsp_valid && bank_rsp_ready) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexp", 64'(rsp_valid), 64'hFFFF);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_vec", 64'(rsp_valid), 64'(1 << r.port));
        check("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
        check("rsp_meta", 64'(rsp_meta), 64'(r.meta));
      end
    end
    @(negedge clk);
  endtask

  task automatic send_rsp(input int p, input logic [31:0] d);
    logic m;
    m              = ~p[0];
    bank_rsp_valid = 1'b1;
    bank_rsp_meta  = {IW'(p), m};
    bank_rsp_rdata = d;
    rsp_ready      = '1;
    exp_rsp(p, d, m);
    #1;
    check("rsp_route", 64'(rsp_valid), 64'(1 << p));
    tick();
    bank_rsp_valid = 1'b0;
  endtask

  task automatic drain(input int p, input int n);
    for (int k = 0; k < n; k++) send_rsp(p, $urandom);
  endtask

  task automatic issue_loads(input int p, input int n,
                             input string tag);
    set_req(p, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < n; k++) begin
      #1;
      check(tag, 64'(req_ready), 64'(1 << p));
      exp_gnt(p);
      tick();
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    req_write      = '0;
    req_amo        = '0;
    rsp_ready      = '0;
    bank_ready     = 1'b1;
    bank_rsp_valid = 1'b1;
    bank_rsp_rdata = '0;
    bank_rsp_meta  = '0;
    for (int p = 0; p < NP; p++) begin
      req_addr[p*AW +: AW]  = addr_of(p);
      req_wdata[p*DW +: DW] = wdata_of(p);
      req_be[p*BW +: BW]    = be_of(p);
      req_meta[p]           = p[0];
    end
    req_valid[0] = 1'b1;
    #1;
    check("rst_bank_valid", 64'(bank_valid), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    bank_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Round robin from pointer 0, then wrap.
    set_req(0, 1'b1, 1'b0, 4'h0);
    set_req(2, 1'b1, 1'b0, 4'h0);
    #1;
    check("t1_c0", 64'(req_ready), 64'b0001);
    exp_gnt(0);
    tick();
    #1;
    check("t1_c1", 64'(req_ready), 64'b0100);
    exp_gnt(2);
    tick();
    #1;
    check("t1_wrap", 64'(req_ready), 64'b0001);
    exp_gnt(0);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0);
    set_req(2, 1'b0, 1'b0, 4'h0);
    drain(0, 2);
    drain(2, 1);

    // Store from port 3 moves the pointer back to 0.
    set_req(3, 1'b1, 1'b1, 4'h0);
    #1;
    check("t2_st3", 64'(req_ready), 64'b1000);
    exp_gnt(3);
    tick();
    set_req(3, 1'b0, 1'b0, 4'h0);

    // Stalled grant stays on port 1 even when port 0 shows up.
    bank_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_req(0, 1'b1, 1'b0, 4'h0);
      #1;
      check("t2_valid", 64'(bank_valid), 64'h1);
      check("t2_idx", 64'(bank_meta[IW+MW-1:MW]), 64'h1);
      check("t2_addr", 64'(bank_addr), 64'(addr_of(1)));
      check("t2_rdy", 64'(req_ready), 64'h0);
      tick();
    end
    bank_ready = 1'b1;
    #1;
    check("t2_gnt1", 64'(req_ready), 64'b0010);
    exp_gnt(1);
    tick();
    set_req(1, 1'b0, 1'b0, 4'h0);
    #1;
    check("t2_gnt0", 64'(req_ready), 64'b0001);
    exp_gnt(0);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0);
    drain(1, 1);
    drain(0, 1);

    // Credit exhaustion: loads blocked, plain store passes.
    issue_loads(0, 4, "t3_ld");
    #1;
    check("t3_full_rdy", 64'(req_ready), 64'h0);
    check("t3_full_vld", 64'(bank_valid), 64'h0);
    tick();
    set_req(0, 1'b1, 1'b1, 4'h0);
    #1;
    check("t3_store", 64'(req_ready), 64'b0001);
    exp_gnt(0);
    tick();
    set_req(0, 1'b0, 1'b0, 4'h0);

    // SC consumes a credit; LR and SC both block once full.
    set_req(1, 1'b1, 1'b1, 4'hB);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_sc", 64'(req_ready), 64'b0010);
      exp_gnt(1);
      tick();
    end
    #1;
    check("t3_sc_full", 64'(req_ready), 64'h0);
    tick();
    set_req(1, 1'b1, 1'b0, 4'hA);
    #1;
    check("t3_lr_full", 64'(req_ready), 64'h0);
    tick();
    set_req(1, 1'b0, 1'b0, 4'h0);
    drain(0, 4);
    drain(1, 4);

    // Response back-pressure on port 3.
    issue_loads(3, 4, "t4_ld");
    bank_rsp_valid = 1'b1;
    bank_rsp_meta  = {IW'(3), 1'b0};
    bank_rsp_rdata = 32'hDEAD_BEEF;
    rsp_ready      = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t4_vec", 64'(rsp_valid), 64'b1000);
      check("t4_brdy", 64'(bank_rsp_ready), 64'h0);
      check("t4_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
      check("t4_blk", 64'(req_ready), 64'h0);
      tick();
    end
    rsp_ready = '1;
    exp_rsp(3, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("t4_brdy_hs", 64'(bank_rsp_ready), 64'h1);
    check("t4_same_cyc", 64'(req_ready), 64'h0);
    tick();
    bank_rsp_valid = 1'b0;
    #1;
    check("t4_regrant", 64'(req_ready), 64'b1000);
    exp_gnt(3);
    tick();
    set_req(3, 1'b0, 1'b0, 4'h0);
    drain(3, 4);

    // Credit return and new load from port 2 in the same cycle.
    issue_loads(2, 4, "t5_ld");
    bank_rsp_valid = 1'b1;
    bank_rsp_meta  = {IW'(2), 1'b1};
    bank_rsp_rdata = 32'h1234_5678;
    exp_rsp(2, 32'h1234_5678, 1'b1);
    #1;
    check("t5_blk_rdy", 64'(req_ready), 64'h0);
    check("t5_blk_vld", 64'(bank_valid), 64'h0);
    tick();
    bank_rsp_valid = 1'b0;
    #1;
    check("t5_next", 64'(req_ready), 64'b0100);
    exp_gnt(2);
    tick();
    set_req(2, 1'b0, 1'b0, 4'h0);
    drain(2, 4);

`ifdef TCDM_BANK_ARB_PERF_EN
    rst = 1'b1;
    #1;
    check("t6_rst", 64'(perf_conflict) | 64'(|perf_grant),
          64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) set_req(p, 1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 10; k++) begin
      exp_gnt(k % 3);
      tick();
    end
    for (int p = 0; p < 3; p++) set_req(p, 1'b0, 1'b0, 4'h0);
    #1;
    check("t6_conflict", 64'(perf_conflict), 64'd10);
    check("t6_sum", 64'(perf_grant[0 +: 32]) +
          64'(perf_grant[32 +: 32]) + 64'(perf_grant[64 +: 32]) +
          64'(perf_grant[96 +: 32]), 64'd10);
    check("t6_p0", 64'(perf_grant[0 +: 32]), 64'd4);
`endif

    check("gnt_q_left", 64'(gnt_q.size()), 64'h0);
    check("rsp_q_left", 64'(rsp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
